ex_div: RTL and testbench
=========================

# ex_div

Multi-cycle 32-bit integer divider in the EX stage. It computes quotient and remainder for DIV/DIVU. EX holds the pipeline stalled while the divider is busy, then forwards the results as the HI/LO write data that EX passes to MEM (`write_hi_data`/`write_lo_data`). The divider is a radix-2 restoring design: one quotient bit per cycle, operands captured at start, results held until EX releases the request.

## Interface
Parameters:
- none (width fixed at 32 via `DATA_BUS`)

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge
- `rst`  in  1  — asynchronous, active-low reset; clears all state and outputs immediately
- `start_in`  in  1  — divide request; held high by EX until `ready_out` seen
- `annul_in`  in  1  — cancel in-flight divide (pipeline flush)
- `signed_div_in`  in  1  — 1 = DIV (signed), 0 = DIVU
- `opdata1_in`  in  32  — dividend
- `opdata2_in`  in  32  — divisor
- `write_lo_data_out`  out  32  — quotient → LO
- `write_hi_data_out`  out  32  — remainder → HI
- `ready_out`  out  1  — result valid; EX uses `!ready_out && start_in` as its stall request

## Operation
- States: `DIV_FREE`, `DIV_BY_ZERO`, `DIV_ON`, `DIV_END`. Reset state is `DIV_FREE`; all outputs reset to 0.
- **DIV_FREE**
  - On `start_in=1` and `annul_in=0`: capture the operands.
  - If divisor == 0, go to `DIV_BY_ZERO`; otherwise go to `DIV_ON` with cnt=0.
  - Signed mode: capture `|opdata1|` and `|opdata2|` (two's-complement negate if negative) and latch both sign bits.
- **DIV_BY_ZERO**
  - Next edge: go to `DIV_END` with quotient = 0 and remainder = 0.
- **DIV_ON**
  - 65-bit working register: {remainder, quotient}.
  - Each cycle: trial-subtract the 33-bit {rem[31:0], q[31]} minus {1'b0, divisor}.
  - If no borrow, shift in a 1 and keep the difference; otherwise shift in a 0.
  - cnt increments each cycle. The cycle with cnt==31 is the last iteration; next state is `DIV_END`.
  - If `annul_in=1`, go to `DIV_FREE` on the next edge. The iteration is discarded and outputs stay 0.
- **DIV_END**
  - Registers the results with sign fix-up:
    - quotient is negated if the dividend and divisor signs differ;
    - remainder is negated if the dividend is negative;
    - fix-up applies only in signed mode.
  - Asserts `ready_out`.
  - When `start_in=0`, go to `DIV_FREE`, and clear `ready_out` and both data outputs to 0 on that edge.
- Operand changes after capture are ignored.
- `start_in` while in `DIV_ON`, `DIV_BY_ZERO` or `DIV_END` has no effect (no re-launch).
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0 (mod-2^32 result, no trap).

## Timing
- E0 = the edge that samples `start_in=1` in `DIV_FREE`.
- Normal divide:
  - iterations occur on E1..E32, and `DIV_END` is entered at E32;
  - results and `ready_out=1` are registered at E33 and visible in the cycle after E33;
  - latency: 33 edges from request to ready.
- Divide by zero: `DIV_END` at E1, `ready_out=1` after E2.
- `ready_out` stays high until the first edge sampling `start_in=0`. It falls on that edge, and the state returns to `DIV_FREE` on that same edge.
- A new request is accepted on the next edge at the earliest, so back-to-back divides have 1 idle cycle.
- Asynchronous reset mid-operation:
  - immediate return to `DIV_FREE`, outputs 0, no result produced;
  - after release, behaviour is identical to power-up.
- `annul_in` has priority over `start_in` in every state except `DIV_END`. In `DIV_END` the result remains until `start_in` drops.

## Configuration
- `DIV_SIGNED_EN` defined:
  - `signed_div_in` is honoured;
  - absolute-value capture and sign fix-up logic are present.
- `DIV_SIGNED_EN` undefined:
  - all divides are unsigned;
  - `signed_div_in` is ignored but the port is kept;
  - no negate logic is synthesised.

## Test plan
- Unsigned divide: 100 / 7 (DIVU), start held → `ready_out` rises after E33; LO=14, HI=2; outputs return to 0 one edge after `start_in` drops.
- Signed divide (`DIV_SIGNED_EN`): -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Same operands unsigned → LO=0x7FFFFFFC, HI=1.
- Divide by zero: 5 / 0 → `ready_out` after E2; LO=0, HI=0; no `DIV_ON` cycles.
- Annul: assert `annul_in` at E10 of a divide → `DIV_FREE` at E11; `ready_out` never rises; a fresh 9 / 3 request afterwards → LO=3, HI=0.
- Reset and overflow:
  - drop `rst` at E20 → outputs 0 immediately;
  - after release, 0x80000000 / 0xFFFFFFFF signed → LO=0x80000000, HI=0.
- Operand stability: change `opdata1_in`/`opdata2_in` at E5 → result reflects the operands captured at E0.

Source files
------------

// File: rtl/ex_div.sv
// rtl/ex_div.sv - radix-2 restoring 32-bit divider for the EX stage (DIV/DIVU)
// Optional signed support is enabled with `define DIV_SIGNED_EN.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic        annul_in,
  input  logic        signed_div_in,
  input  logic [31:0] opdata1_in,
  input  logic [31:0] opdata2_in,
  output logic [31:0] write_lo_data_out,
  output logic [31:0] write_hi_data_out,
  output logic        ready_out
);

  localparam int DATA_BUS = 32;

  typedef enum logic [1:0] {DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END} state_t;

  state_t              state, state_nxt;
  logic [4:0]          cnt;
  logic [DATA_BUS-1:0] rem, quo, dvsr;
  logic [DATA_BUS:0]   diff;
  logic                load, step, finish;
  logic [DATA_BUS-1:0] op1_abs, op2_abs, quo_fix, rem_fix;

`ifdef DIV_SIGNED_EN
  logic neg1, neg2, neg_q, neg_r;

  assign neg1    = signed_div_in & opdata1_in[DATA_BUS-1];
  assign neg2    = signed_div_in & opdata2_in[DATA_BUS-1];
  assign op1_abs = neg1 ? -opdata1_in : opdata1_in;
  assign op2_abs = neg2 ? -opdata2_in : opdata2_in;
  assign quo_fix = neg_q ? -quo : quo;
  assign rem_fix = neg_r ? -rem : rem;

  // Remainder takes the dividend's sign; quotient is negative when signs differ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      neg_q <= neg1 ^ neg2;
      neg_r <= neg1;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_div_in;
  assign op1_abs       = opdata1_in;
  assign op2_abs       = opdata2_in;
  assign quo_fix       = quo;
  assign rem_fix       = rem;
`endif

  // Trial subtraction of the divisor from the partial remainder plus next dividend bit.
  assign diff = {rem, quo[DATA_BUS-1]} - {1'b0, dvsr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_FREE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_FREE:    if (start_in && !annul_in)
                     state_nxt = (opdata2_in == '0) ? DIV_BY_ZERO : DIV_ON;
      DIV_BY_ZERO: state_nxt = annul_in ? DIV_FREE : DIV_END;
      DIV_ON:      if (annul_in)          state_nxt = DIV_FREE;
                   else if (cnt == 5'd31) state_nxt = DIV_END;
      DIV_END:     if (!start_in) state_nxt = DIV_FREE;
      default:     state_nxt = DIV_FREE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      DIV_FREE: load   = start_in && !annul_in;
      DIV_ON:   step   = !annul_in;
      DIV_END:  finish = start_in;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt               <= '0;
      rem               <= '0;
      quo               <= '0;
      dvsr              <= '0;
      write_lo_data_out <= '0;
      write_hi_data_out <= '0;
      ready_out         <= 1'b0;
    end else begin
      if (load) begin
        // A zero divisor leaves quotient and remainder at 0 for the result.
        rem  <= '0;
        quo  <= (opdata2_in == '0) ? '0 : op1_abs;
        dvsr <= op2_abs;
        cnt  <= '0;
      end else if (step) begin
        cnt <= cnt + 5'd1;
        if (!diff[DATA_BUS]) begin
          rem <= diff[DATA_BUS-1:0];
          quo <= {quo[DATA_BUS-2:0], 1'b1};
        end else begin
          rem <= {rem[DATA_BUS-2:0], quo[DATA_BUS-1]};
          quo <= {quo[DATA_BUS-2:0], 1'b0};
        end
      end
      ready_out         <= finish;
      write_lo_data_out <= finish ? quo_fix : '0;
      write_hi_data_out <= finish ? rem_fix : '0;
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - scoreboard bench for ex_div (signed cases follow DIV_SIGNED_EN)
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_in = 1'b0;
  logic        annul_in = 1'b0;
  logic        signed_div_in = 1'b0;
  logic [31:0] opdata1_in = '0;
  logic [31:0] opdata2_in = '0;
  logic [31:0] write_lo_data_out, write_hi_data_out;
  logic        ready_out;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];

  ex_div dut (
    .clk              (clk),
    .rst              (rst),
    .start_in         (start_in),
    .annul_in         (annul_in),
    .signed_div_in    (signed_div_in),
    .opdata1_in       (opdata1_in),
    .opdata2_in       (opdata2_in),
    .write_lo_data_out(write_lo_data_out),
    .write_hi_data_out(write_hi_data_out),
    .ready_out        (ready_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result as {quotient, remainder}; signed uses 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {q[31:0], r[31:0]};
    end
`else
    if (sgn) sa = 0;
`endif
    return {a / b, a % b};
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int chg_at);
    logic [63:0] e;
    int          n;
    @(negedge clk);
    start_in      = 1'b1;
    signed_div_in = sgn;
    opdata1_in    = a;
    opdata2_in    = b;
    exp_q.push_back(model(a, b, sgn));
    n = 0;
    while (!ready_out && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == chg_at) begin
        opdata1_in = $urandom;
        opdata2_in = $urandom;
      end
    end
    check("latency", n, (b == 32'd0) ? 32'd3 : 32'd34);
    e = exp_q.pop_front();
    check("lo", write_lo_data_out, e[63:32]);
    check("hi", write_hi_data_out, e[31:0]);
    @(posedge clk); #1;
    check("ready_held", {31'd0, ready_out}, 32'd1);
    @(negedge clk);
    start_in = 1'b0;
    @(posedge clk); #1;
    check("ready_clr", {31'd0, ready_out}, 32'd0);
    check("lo_clr", write_lo_data_out, 32'd0);
    check("hi_clr", write_hi_data_out, 32'd0);
  endtask

  initial begin
    int n;
    #1;
    check("rst_ready", {31'd0, ready_out}, 32'd0);
    check("rst_lo", write_lo_data_out, 32'd0);
    check("rst_hi", write_hi_data_out, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, 0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b0, 0);
    run_div(32'd5, 32'd0, 1'b0, 0);
    run_div(32'd1000, 32'd7, 1'b0, 6);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      run_div($urandom, $urandom_range(1, 5000), 1'($urandom_range(0, 1)), 0);

    // Annul sampled at E10 while start is still held.
    @(negedge clk);
    start_in   = 1'b1;
    opdata1_in = 32'd1000;
    opdata2_in = 32'd3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_in = 1'b1;
    @(negedge clk);
    annul_in = 1'b0;
    start_in = 1'b0;
    @(posedge clk); #1;
    check("annul_ready", {31'd0, ready_out}, 32'd0);
    run_div(32'd9, 32'd3, 1'b0, 0);

    // Asynchronous reset at E20 of a divide.
    @(negedge clk);
    start_in   = 1'b1;
    opdata1_in = 32'd100;
    opdata2_in = 32'd7;
    repeat (21) @(posedge clk);
    #2 rst = 1'b0;
    start_in = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, ready_out}, 32'd0);
    check("rst_mid_lo", write_lo_data_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0);

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    start_in   = 1'b1;
    opdata1_in = 32'd20;
    opdata2_in = 32'd6;
    n = 0;
    while (!ready_out && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_ready", {31'd0, ready_out}, 32'd1);
    check("hold_lo", write_lo_data_out, 32'd3);
    #2 rst = 1'b0;
    #1;
    check("rst_end_ready", {31'd0, ready_out}, 32'd0);
    check("rst_end_hi", write_hi_data_out, 32'd0);
    start_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div(32'd77, 32'd11, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
